// File: rtl/rf_read_sequencer.sv
// Read-side burst sequencer for the lab register file: walks a wrapping address
// range one entry per ADDR/SEND pair and streams the captured words on valid/ready.
module rf_read_sequencer #(
    parameter int WIDTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AW-1:0]    req_addr,
    input  logic [AW-1:0]    req_len,
    output logic             rf_rd_en,
    output logic [AW-1:0]    rf_addr,
    input  logic [WIDTH-1:0] rf_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW-1:0]    rd_addr,
    output logic             rd_last,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] cur_addr;
    logic [AW-1:0] remaining;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = ADDR;
            ADDR:    state_nxt = SEND;
            SEND:    if (rd_ready) state_nxt = rd_last ? IDLE : ADDR;
            default: state_nxt = IDLE;
        endcase
    end

    // rf_addr is forced to zero outside ADDR so the bank sees a quiet bus.
    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
        rf_rd_en  = (state == ADDR);
        rf_addr   = (state == ADDR) ? cur_addr : '0;
        rd_valid  = (state == SEND);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_addr  <= '0;
            remaining <= '0;
            rd_data   <= '0;
            rd_addr   <= '0;
            rd_last   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cur_addr  <= req_addr;
                        remaining <= req_len;
                    end
                end
                ADDR: begin
                    rd_data <= rf_data;
                    rd_addr <= cur_addr;
                    rd_last <= (remaining == '0);
                end
                SEND: begin
                    if (rd_ready) begin
                        if (rd_last) begin
                            rd_last <= 1'b0;
                        end else begin
                            // Address wraps naturally at AW bits.
                            cur_addr  <= cur_addr + AW'(1);
                            remaining <= remaining - AW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
